hazard3_ahbl_arbiter_n: RTL and testbench

// - N-port arbiter merging core-style address/data-phase request interfaces onto one AHB-Lite master port.
// - Generalises the 2-port I/D arbitration in the 1-port CPU top: any port count, per-port panic override, per-port HPROT.
// - Sits between one or more Hazard3 cores (or core + DMA) and the system bus.
// - Also selectable round-robin fairness.

---
 rtl/hazard3_ahbl_arbiter_n_if.sv | 52 +++++
 rtl/hazard3_ahbl_arbiter_n.sv | 141 ++++++++++++++
 tb/tb_hazard3_ahbl_arbiter_n.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard3_ahbl_arbiter_n_if.sv
// Signal bundle for hazard3_ahbl_arbiter_n: N upstream core-style request ports plus the merged
// AHB-Lite master port. The master modport is the arbiter's view, the slave modport the environment's.
interface hazard3_ahbl_arbiter_n_if #(
   parameter int unsigned N_PORTS = 2,
   parameter int unsigned W_ADDR  = 32,
   parameter int unsigned W_DATA  = 32
);

   // Upstream request side, port k occupies slice k of each flattened vector
   logic [N_PORTS-1:0]        up_aph_req;
   logic [N_PORTS-1:0]        up_aph_panic;
   logic [N_PORTS*W_ADDR-1:0] up_haddr;
   logic [N_PORTS*3-1:0]      up_hsize;
   logic [N_PORTS-1:0]        up_hwrite;
   logic [N_PORTS*4-1:0]      up_hprot;
   logic [N_PORTS*W_DATA-1:0] up_wdata;
   logic [N_PORTS-1:0]        up_aph_ready;
   logic [N_PORTS-1:0]        up_dph_ready;
   logic [N_PORTS-1:0]        up_dph_err;
   logic [W_DATA-1:0]         up_rdata;
   logic [N_PORTS-1:0]        gnt_onehot;

   // Merged AHB-Lite master port
   logic [W_ADDR-1:0]         ahblm_haddr;
   logic                      ahblm_hwrite;
   logic [1:0]                ahblm_htrans;
   logic [2:0]                ahblm_hsize;
   logic [2:0]                ahblm_hburst;
   logic [3:0]                ahblm_hprot;
   logic                      ahblm_hmastlock;
   logic                      ahblm_hready;
   logic                      ahblm_hresp;
   logic [W_DATA-1:0]         ahblm_hwdata;
   logic [W_DATA-1:0]         ahblm_hrdata;

   modport master (
      input  up_aph_req, up_aph_panic, up_haddr, up_hsize, up_hwrite, up_hprot, up_wdata,
      output up_aph_ready, up_dph_ready, up_dph_err, up_rdata, gnt_onehot,
      output ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize, ahblm_hburst, ahblm_hprot,
      output ahblm_hmastlock, ahblm_hwdata,
      input  ahblm_hready, ahblm_hresp, ahblm_hrdata
   );

   modport slave (
      output up_aph_req, up_aph_panic, up_haddr, up_hsize, up_hwrite, up_hprot, up_wdata,
      input  up_aph_ready, up_dph_ready, up_dph_err, up_rdata, gnt_onehot,
      input  ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize, ahblm_hburst, ahblm_hprot,
      input  ahblm_hmastlock, ahblm_hwdata,
      output ahblm_hready, ahblm_hresp, ahblm_hrdata
   );

endinterface

// File: rtl/hazard3_ahbl_arbiter_n.sv
// N-port arbiter merging core-style address/data-phase requests onto one AHB-Lite master port.
// Define HAZARD3_ARB_ROUND_ROBIN_EN for round-robin selection among non-panic requests.
module hazard3_ahbl_arbiter_n #(
   parameter int unsigned N_PORTS = 2,
   parameter int unsigned W_ADDR  = 32,
   parameter int unsigned W_DATA  = 32
) (
   input  logic                     clk,
   input  logic                     rst_n,
   hazard3_ahbl_arbiter_n_if.master bus
);

   localparam logic [1:0] HTRANS_IDLE = 2'b00;
   localparam logic [1:0] HTRANS_NSEQ = 2'b10;

   logic               hold_aph;
   logic [N_PORTS-1:0] gnt_prev;
   logic [N_PORTS-1:0] dph_owner;
   logic [N_PORTS-1:0] gnt;
   logic [N_PORTS-1:0] panic_first;
   logic [N_PORTS-1:0] req_first;

   // Lowest set bit isolates the lowest-index (highest priority) candidate
   assign panic_first = bus.up_aph_panic & (~bus.up_aph_panic + N_PORTS'(1));

`ifdef HAZARD3_ARB_ROUND_ROBIN_EN
   localparam int unsigned W_IDX = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

   logic [W_IDX-1:0]   rr_last;
   logic [W_IDX-1:0]   gnt_idx;
   logic               gnt_panic;
   logic               gnt_panic_prev;
   logic [N_PORTS-1:0] rr_above;
   logic [N_PORTS-1:0] req_above;

   // Ports strictly above rr_last get first look; wrap to the bottom if none of them request
   assign rr_above  = ~((N_PORTS'(2) << rr_last) - N_PORTS'(1));
   assign req_above = bus.up_aph_req & rr_above;

   always_comb begin
      req_first = '0;
      if (|req_above) begin
         req_first = req_above & (~req_above + N_PORTS'(1));
      end else begin
         req_first = bus.up_aph_req & (~bus.up_aph_req + N_PORTS'(1));
      end
   end

   // A held grant keeps the panic/non-panic origin it had when first selected
   always_comb begin
      gnt_panic = |bus.up_aph_panic;
      if (hold_aph) begin
         gnt_panic = gnt_panic_prev;
      end
   end

   always_comb begin
      gnt_idx = '0;
      for (int unsigned k = 0; k < N_PORTS; k++) begin
         if (gnt[k]) begin
            gnt_idx = W_IDX'(k);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_last        <= W_IDX'(N_PORTS - 1);
         gnt_panic_prev <= 1'b0;
      end else begin
         gnt_panic_prev <= gnt_panic;
         if (bus.ahblm_hready && (|gnt) && !gnt_panic) begin
            rr_last <= gnt_idx;
         end
      end
   end
`else
   assign req_first = bus.up_aph_req & (~bus.up_aph_req + N_PORTS'(1));
`endif

   // Grant: held address phase, then panic, then ordinary requests
   always_comb begin
      gnt = '0;
      if (hold_aph) begin
         gnt = gnt_prev;
      end else if (|bus.up_aph_panic) begin
         gnt = panic_first;
      end else begin
         gnt = req_first;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_aph  <= 1'b0;
         gnt_prev  <= '0;
         dph_owner <= '0;
      end else begin
         hold_aph <= (|gnt) && !bus.ahblm_hready;
         gnt_prev <= gnt;
         if (bus.ahblm_hready) begin
            dph_owner <= gnt;
         end
      end
   end

   // Address-phase mux; an idle bus presents all-zero control
   always_comb begin
      bus.ahblm_htrans = (|gnt) ? HTRANS_NSEQ : HTRANS_IDLE;
      bus.ahblm_haddr  = '0;
      bus.ahblm_hsize  = 3'b000;
      bus.ahblm_hwrite = 1'b0;
      bus.ahblm_hprot  = 4'b0000;
      for (int unsigned k = 0; k < N_PORTS; k++) begin
         if (gnt[k]) begin
            bus.ahblm_haddr  = bus.up_haddr[k*W_ADDR +: W_ADDR];
            bus.ahblm_hsize  = bus.up_hsize[k*3 +: 3];
            bus.ahblm_hwrite = bus.up_hwrite[k];
            bus.ahblm_hprot  = bus.up_hprot[k*4 +: 4];
         end
      end
   end

   always_comb begin
      bus.ahblm_hwdata = '0;
      for (int unsigned k = 0; k < N_PORTS; k++) begin
         if (dph_owner[k]) begin
            bus.ahblm_hwdata = bus.up_wdata[k*W_DATA +: W_DATA];
         end
      end
   end

   assign bus.ahblm_hburst    = 3'b000;
   assign bus.ahblm_hmastlock = 1'b0;
   assign bus.up_aph_ready    = gnt & {N_PORTS{bus.ahblm_hready}};
   assign bus.up_dph_ready    = dph_owner & {N_PORTS{bus.ahblm_hready}};
   assign bus.up_dph_err      = dph_owner & {N_PORTS{bus.ahblm_hresp}};
   assign bus.up_rdata        = bus.ahblm_hrdata;
   assign bus.gnt_onehot      = gnt;

endmodule

// File: tb/tb_hazard3_ahbl_arbiter_n.sv
// Bench for hazard3_ahbl_arbiter_n (N=3): directed scenarios then random traffic, all checked
// against a port-index reference model. Tracks HAZARD3_ARB_ROUND_ROBIN_EN like the design.
module tb_hazard3_ahbl_arbiter_n;

   localparam int unsigned N  = 3;
   localparam int unsigned WA = 32;
   localparam int unsigned WD = 32;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hazard3_ahbl_arbiter_n_if #(.N_PORTS(N), .W_ADDR(WA), .W_DATA(WD)) bus ();

   hazard3_ahbl_arbiter_n #(.N_PORTS(N), .W_ADDR(WA), .W_DATA(WD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Stimulus state, per port
   logic [N-1:0]  req, panic, hwr;
   logic [WA-1:0] addr  [N];
   logic [2:0]    size  [N];
   logic [3:0]    prot  [N];
   logic [WD-1:0] wdata [N];
   logic          hready, hresp;
   logic [WD-1:0] hrdata;

   int checks = 0;
   int errors = 0;

   // Reference model: ports as integer indices, -1 meaning none
   bit m_hold;
   int m_held;
   bit m_held_panic;
   int m_dph;
   int m_rr_last;

   function automatic logic [63:0] onehot(input int g);
      return (g >= 0) ? (64'(1) << g) : 64'(0);
   endfunction

   function automatic int model_grant(output bit from_panic);
      from_panic = 1'b0;
      if (m_hold) begin
         from_panic = m_held_panic;
         return m_held;
      end
      for (int k = 0; k < int'(N); k++) begin
         if (panic[k]) begin
            from_panic = 1'b1;
            return k;
         end
      end
`ifdef HAZARD3_ARB_ROUND_ROBIN_EN
      for (int i = 1; i <= int'(N); i++) begin
         int p;
         p = (m_rr_last + i) % int'(N);
         if (req[p]) return p;
      end
`else
      for (int k = 0; k < int'(N); k++) begin
         if (req[k]) return k;
      end
`endif
      return -1;
   endfunction

   task automatic model_reset();
      m_hold       = 1'b0;
      m_held       = -1;
      m_held_panic = 1'b0;
      m_dph        = -1;
      m_rr_last    = int'(N) - 1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      bus.up_aph_req   = req;
      bus.up_aph_panic = panic;
      bus.up_hwrite    = hwr;
      for (int k = 0; k < int'(N); k++) begin
         bus.up_haddr[k*WA +: WA] = addr[k];
         bus.up_hsize[k*3 +: 3]   = size[k];
         bus.up_hprot[k*4 +: 4]   = prot[k];
         bus.up_wdata[k*WD +: WD] = wdata[k];
      end
      bus.ahblm_hready = hready;
      bus.ahblm_hresp  = hresp;
      bus.ahblm_hrdata = hrdata;
   endtask

   // One cycle: drive, check outputs against the model (and an explicit grant if want != -2), clock
   task automatic step(input int want);
      int g;
      int d;
      bit fp;
      drive();
      #1;
      g = model_grant(fp);
      d = m_dph;
      if (want != -2) chk("spec_gnt", 64'(bus.gnt_onehot), onehot(want));
      chk("gnt",       64'(bus.gnt_onehot),      onehot(g));
      chk("htrans",    64'(bus.ahblm_htrans),    (g >= 0) ? 64'(2) : 64'(0));
      chk("haddr",     64'(bus.ahblm_haddr),     (g >= 0) ? 64'(addr[g]) : 64'(0));
      chk("hsize",     64'(bus.ahblm_hsize),     (g >= 0) ? 64'(size[g]) : 64'(0));
      chk("hwrite",    64'(bus.ahblm_hwrite),    (g >= 0) ? 64'(hwr[g]) : 64'(0));
      chk("hprot",     64'(bus.ahblm_hprot),     (g >= 0) ? 64'(prot[g]) : 64'(0));
      chk("hburst",    64'(bus.ahblm_hburst),    64'(0));
      chk("hmastlock", 64'(bus.ahblm_hmastlock), 64'(0));
      chk("aph_ready", 64'(bus.up_aph_ready),    hready ? onehot(g) : 64'(0));
      chk("dph_ready", 64'(bus.up_dph_ready),    hready ? onehot(d) : 64'(0));
      chk("dph_err",   64'(bus.up_dph_err),      hresp ? onehot(d) : 64'(0));
      chk("hwdata",    64'(bus.ahblm_hwdata),    (d >= 0) ? 64'(wdata[d]) : 64'(0));
      chk("rdata",     64'(bus.up_rdata),        64'(hrdata));
      @(posedge clk);
      if (rst_n) begin
`ifdef HAZARD3_ARB_ROUND_ROBIN_EN
         if (hready && g >= 0 && !fp) m_rr_last = g;
`endif
         m_hold       = (g >= 0) && !hready;
         m_held       = g;
         m_held_panic = fp;
         if (hready) m_dph = g;
      end
      @(negedge clk);
   endtask

   initial begin
      req = '0; panic = '0; hwr = '0;
      hready = 1'b1; hresp = 1'b0; hrdata = 32'h0;
      for (int k = 0; k < int'(N); k++) begin
         addr[k]  = 32'h100 * (k + 1);
         size[k]  = 3'(k);
         prot[k]  = 4'(k + 3);
         wdata[k] = 32'hA000_0000 + 32'(k);
      end
      model_reset();

      // Reset state with no requests
      rst_n = 1'b0;
      step(-1);
      rst_n = 1'b1;
      step(-1);

      // All three ports requesting continuously with hready high
      req = 3'b111;
      for (int i = 0; i < 6; i++) begin
`ifdef HAZARD3_ARB_ROUND_ROBIN_EN
         step(i % 3);
`else
         step(0);
`endif
      end
      req = '0;
      step(-1);

      // Port 1 stalls 3 cycles; a port-0 panic arriving mid-stall must not preempt it
      req = 3'b010; hready = 1'b0;
      step(1);
      req = 3'b011; panic = 3'b001;
      step(1);
      step(1);
      hready = 1'b1;
      step(1);
      req = 3'b001;
      step(0);
      req = '0; panic = '0;
      step(-1);

      // Port 0 write then port 2 read, back-to-back
      req = 3'b001; hwr = 3'b001; addr[0] = 32'h1000; wdata[0] = 32'hCAFE_F00D;
      step(0);
      req = 3'b100; hwr = 3'b000; addr[2] = 32'h2000;
      drive(); #1;
      chk("b2b_hwdata", 64'(bus.ahblm_hwdata), 64'h0000_0000_CAFE_F00D);
      step(2);
      req = '0; hrdata = 32'h1234_5678;
      drive(); #1;
      chk("b2b_dph_ready", 64'(bus.up_dph_ready), 64'b100);
      chk("b2b_rdata", 64'(bus.up_rdata), 64'h0000_0000_1234_5678);
      step(-1);

      // Two-cycle ERROR response on port 2's data phase
      req = 3'b100;
      step(2);
      req = '0; hresp = 1'b1; hready = 1'b0;
      drive(); #1;
      chk("err1_err", 64'(bus.up_dph_err), 64'b100);
      chk("err1_ready", 64'(bus.up_dph_ready), 64'b000);
      step(-1);
      hready = 1'b1;
      drive(); #1;
      chk("err2_err", 64'(bus.up_dph_err), 64'b100);
      chk("err2_ready", 64'(bus.up_dph_ready), 64'b100);
      step(-1);
      hresp = 1'b0;
      step(-1);

      // Reset asserted in the middle of a stall
      req = 3'b010; hready = 1'b0;
      step(1);
      rst_n = 1'b0; req = '0; hready = 1'b1;
      model_reset();
      drive(); #1;
      chk("rst_htrans", 64'(bus.ahblm_htrans), 64'(0));
      chk("rst_readies", {40'(0), 8'(bus.up_aph_ready), 8'(bus.up_dph_ready), 8'(bus.up_dph_err)}, 64'(0));
      step(-1);
      rst_n = 1'b1; req = 3'b111;
      step(0);
      req = '0;
      step(-1);

      // Random traffic against the model
      for (int i = 0; i < 600; i++) begin
         req    = N'($urandom);
         panic  = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
         hwr    = N'($urandom);
         for (int k = 0; k < int'(N); k++) begin
            addr[k]  = $urandom;
            size[k]  = 3'($urandom);
            prot[k]  = 4'($urandom);
            wdata[k] = $urandom;
         end
         hready = ($urandom_range(0, 3) != 0);
         hresp  = ($urandom_range(0, 7) == 0);
         hrdata = $urandom;
         step(-2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
